// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle ARM32 control unit sequencing fetch, decode, execute, memory and write-back.
module ctrl_fsm #(
  parameter bit COND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] status_in,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        load_ir,
  output logic        load_pc,
  output logic        sel_pc,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic [3:0]  w_addr1,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic        w_en1,
  output logic        sel_w_data,
  output logic [1:0]  sel_A_in,
  output logic        sel_A,
  output logic        sel_B,
  output logic        sel_shift,
  output logic [1:0]  shift_op,
  output logic [31:0] shift_imme,
  output logic [31:0] imme_data,
  output logic [2:0]  ALU_op,
  output logic        en_out1,
  output logic        en_out2,
  output logic        en_status1,
  output logic        en_status2
);
  typedef enum logic [2:0] {FETCH, FETCH_WAIT, DECODE, EXECUTE, MEMORY, MEMORY_WAIT, WRITE_BACK} state_t;
  state_t state, state_n;
  logic [31:0] ir;
  logic dp, ls, br, ls_ok, ldr, str, cmp, mov, dp_ok, reg_b, set_flags, pass, go;
  logic n, z, c, v, unused;
  logic [2:0] dp_alu;
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH;
      ir <= '0;
    end else begin
      state <= state_n;
      if (load_ir) ir <= instr;
    end
  assign {n, z, c, v} = status_in[31:28];
  assign unused = ^status_in[27:0];
  assign dp = ir[27:26] == 2'b00;
  assign ls = ir[27:26] == 2'b01;
  assign br = ir[27:25] == 3'b101;
  assign ls_ok = ls && !ir[25] && ir[24] && !ir[21];
  assign ldr = ls_ok && ir[20];
  assign str = ls_ok && !ir[20];
  assign cmp = dp && ir[24:21] == 4'b1010;
  assign mov = dp && ir[24:21] == 4'b1101;
  assign reg_b = dp && !ir[25];
  assign set_flags = dp_ok && (ir[20] || cmp);
  always_comb begin
    dp_ok = dp;
    case (ir[24:21])
      4'b0000:          dp_alu = 3'b010;
      4'b0001:          dp_alu = 3'b100;
      4'b0010, 4'b1010: dp_alu = 3'b001;
      4'b0100, 4'b1101: dp_alu = 3'b000;
      4'b1100:          dp_alu = 3'b011;
      default: begin
        dp_alu = 3'b000;
        dp_ok = 1'b0;
      end
    endcase
  end
  always_comb
    case (ir[31:28])
      4'h0:    pass = z;
      4'h1:    pass = !z;
      4'h2:    pass = c;
      4'h3:    pass = !c;
      4'h4:    pass = n;
      4'h5:    pass = !n;
      4'h6:    pass = v;
      4'h7:    pass = !v;
      4'h8:    pass = c && !z;
      4'h9:    pass = !c || z;
      4'hA:    pass = n == v;
      4'hB:    pass = n != v;
      4'hC:    pass = !z && n == v;
      4'hD:    pass = z || n != v;
      4'hE:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
  assign go = (pass || !COND_EN) && (dp_ok || ls_ok || br);
  assign A_addr = (dp || ls) ? ir[19:16] : 4'd0;
  assign B_addr = reg_b ? ir[3:0] : str ? ir[15:12] : 4'd0;
  assign w_addr1 = ir[15:12];
  assign shift_op = reg_b ? ir[6:5] : 2'b00;
  assign sel_shift = !rst && reg_b && ir[4];
  assign shift_addr = (reg_b && ir[4]) ? ir[11:8] : 4'd0;
  assign shift_imme = (reg_b && !ir[4]) ? {27'd0, ir[11:7]} : 32'd0;
  assign imme_data = (dp && ir[25]) ? {24'd0, ir[7:0]} :
                     ls ? {20'd0, ir[11:0]} :
                     br ? {{6{ir[23]}}, ir[23:0], 2'b00} : 32'd0;
  // Strobes and EXECUTE-only selects stay low while reset is held.
  always_comb begin
    state_n = state;
    {mem_rd, mem_wr, load_ir, load_pc, sel_pc, en_A, en_B, en_S, w_en1, sel_w_data} = '0;
    {sel_A, sel_B, en_out1, en_out2, en_status1, en_status2} = '0;
    sel_A_in = 2'b00;
    ALU_op = 3'b000;
    if (!rst)
      case (state)
        FETCH: begin
          mem_rd = 1'b1;
          state_n = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          mem_rd = 1'b1;
          load_ir = mem_ready;
          state_n = mem_ready ? DECODE : FETCH_WAIT;
        end
        DECODE: begin
          {en_A, en_B, en_S} = {3{go}};
          load_pc = !go;
          state_n = go ? EXECUTE : FETCH;
        end
        EXECUTE: begin
          en_out1 = 1'b1;
          en_status1 = set_flags;
          sel_A = mov;
          sel_B = (dp && ir[25]) || ls || br;
          sel_A_in = {1'b0, br};
          ALU_op = dp ? dp_alu : (ls && !ir[23]) ? 3'b001 : 3'b000;
          state_n = MEMORY;
        end
        MEMORY: begin
          en_out2 = 1'b1;
          en_status2 = set_flags;
          mem_rd = ldr;
          mem_wr = str;
          state_n = ls_ok ? MEMORY_WAIT : WRITE_BACK;
        end
        MEMORY_WAIT: begin
          mem_rd = ldr;
          mem_wr = str;
          state_n = mem_ready ? WRITE_BACK : MEMORY_WAIT;
        end
        WRITE_BACK: begin
          w_en1 = (dp && !cmp) || ldr;
          sel_w_data = ldr;
          load_pc = 1'b1;
          sel_pc = br;
          state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
  end
endmodule
